// File: rtl/calc_pkg.sv
// Shared calculator constants: sentinel result words, displayable range,
// status encodings, display nibble codes and the converter state type.
// Pure declarations, no logic.
package calc_pkg;

  localparam int NDIG  = 6;
  localparam int MAG_W = 20;
  localparam int BCD_W = NDIG * 4;
  localparam int CNT_W = $clog2(MAG_W);

  localparam logic [31:0] NULL_CODE = 32'h00CC_0000;
  localparam logic [31:0] OVF_CODE  = 32'h00EE_0000;

  localparam int MAX_POS = 999999;
  localparam int MIN_NEG = -99999;

  typedef enum logic [1:0] {
    CODE_NUM  = 2'd0,
    CODE_NULL = 2'd1,
    CODE_OVF  = 2'd2
  } code_e;

  localparam logic [3:0] BLANK = 4'hF;
  localparam logic [3:0] MINUS = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FIN   = 2'd2
  } state_e;

endpackage

// File: rtl/ans_bcd_convert_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift
// {bcd, mag} left by one bit.
// Purely combinational, no handshake.
module bcd_dabble_step import calc_pkg::*; #(
  parameter int NDIG_P  = NDIG,
  parameter int MAG_W_P = MAG_W
) (
  input  logic [NDIG_P*4-1:0] bcd_i,
  input  logic [MAG_W_P-1:0]  mag_i,
  output logic [NDIG_P*4-1:0] bcd_o,
  output logic [MAG_W_P-1:0]  mag_o
);

  logic [NDIG_P*4-1:0] adj;
  // The carry out of the top digit is always zero for in-range magnitudes.
  logic                unused_msb;

  // Per-nibble add-3 correction ahead of the shift.
  always_comb begin
    adj = bcd_i;
    for (int i = 0; i < NDIG_P; i++) begin
      if (bcd_i[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = bcd_i[i*4 +: 4] + 4'd3;
      end
    end
  end

  assign unused_msb     = adj[NDIG_P*4-1];
  assign {bcd_o, mag_o} = {adj[NDIG_P*4-2:0], mag_i, 1'b0};

endmodule

// File: rtl/ans_bcd_convert.sv
// Converts the 32-bit calculator result into six BCD digits, sign and status.
// Latency: numeric done one cycle after E21, sentinels one cycle after E1.
// start is ignored while busy. Optional macro ANS_BCD_BLANK_EN blanks leading zeros.
module ans_bcd_convert import calc_pkg::*; (
  input  logic        sw_clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] ans,
  output logic        busy,
  output logic        done,
  output logic [23:0] digits,
  output logic        neg,
  output logic [1:0]  code
);

  state_e             state_q, state_d;
  logic [MAG_W-1:0]   mag_q, mag_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  code_e              pcode_q, pcode_d;
  logic               pneg_q, pneg_d;
  logic [BCD_W-1:0]   dig_q, dig_d;
  logic               neg_q, neg_d;
  code_e              code_q, code_d;
  logic               done_q, done_d;

  logic signed [31:0] ans_s;
  logic               is_null;
  logic               is_ovf;
  logic [MAG_W-1:0]   ans_mag;
  logic [BCD_W-1:0]   step_bcd;
  logic [MAG_W-1:0]   step_mag;
  logic [BCD_W-1:0]   fin_dig;

  assign ans_s   = ans;
  assign is_null = (ans == NULL_CODE);
  assign is_ovf  = (ans == OVF_CODE) || (ans_s < MIN_NEG) || (ans_s > MAX_POS);
  // Negating only the low bits is exact because in-range values fit in MAG_W.
  assign ans_mag = ans[31] ? (~ans[MAG_W-1:0] + MAG_W'(1)) : ans[MAG_W-1:0];

  bcd_dabble_step #(
    .NDIG_P  (NDIG),
    .MAG_W_P (MAG_W)
  ) u_step (
    .bcd_i (bcd_q),
    .mag_i (mag_q),
    .bcd_o (step_bcd),
    .mag_o (step_mag)
  );

`ifdef ANS_BCD_BLANK_EN
  logic seen_nz;

  // Display formatting: blank leading zeros, put a minus just above the MSD.
  always_comb begin
    fin_dig = bcd_q;
    seen_nz = 1'b0;
    if (pcode_q != CODE_NUM) begin
      fin_dig = {NDIG{BLANK}};
    end else begin
      for (int i = NDIG - 1; i > 0; i--) begin
        if (!seen_nz) begin
          if (bcd_q[i*4 +: 4] != 4'd0) seen_nz = 1'b1;
          else                         fin_dig[i*4 +: 4] = BLANK;
        end
      end
      for (int i = NDIG - 1; i > 0; i--) begin
        if (pneg_q && fin_dig[i*4 +: 4] == BLANK && fin_dig[(i-1)*4 +: 4] != BLANK) begin
          fin_dig[i*4 +: 4] = MINUS;
        end
      end
    end
  end
`else
  // Raw BCD with leading zeros; sentinels show all zeros.
  always_comb begin
    fin_dig = (pcode_q == CODE_NUM) ? bcd_q : '0;
  end
`endif

  // Next-state and datapath updates for IDLE -> SHIFT x MAG_W -> FIN.
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    pcode_d = pcode_q;
    pneg_d  = pneg_q;
    dig_d   = dig_q;
    neg_d   = neg_q;
    code_d  = code_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_null) begin
            pcode_d = CODE_NULL;
            pneg_d  = 1'b0;
            state_d = ST_FIN;
          end else if (is_ovf) begin
            pcode_d = CODE_OVF;
            pneg_d  = 1'b0;
            state_d = ST_FIN;
          end else begin
            pcode_d = CODE_NUM;
            pneg_d  = ans[31];
            mag_d   = ans_mag;
            bcd_d   = '0;
            cnt_d   = '0;
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        bcd_d = step_bcd;
        mag_d = step_mag;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MAG_W - 1)) state_d = ST_FIN;
      end
      ST_FIN: begin
        dig_d   = fin_dig;
        neg_d   = (pcode_q == CODE_NUM) ? pneg_q : 1'b0;
        code_d  = pcode_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sw_clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Datapath and output registers.
  always_ff @(posedge sw_clk or negedge rst) begin
    if (!rst) begin
      mag_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      pcode_q <= CODE_NUM;
      pneg_q  <= 1'b0;
      dig_q   <= '0;
      neg_q   <= 1'b0;
      code_q  <= CODE_NUM;
      done_q  <= 1'b0;
    end else begin
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      pcode_q <= pcode_d;
      pneg_q  <= pneg_d;
      dig_q   <= dig_d;
      neg_q   <= neg_d;
      code_q  <= code_d;
      done_q  <= done_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;
  assign digits = dig_q;
  assign neg    = neg_q;
  assign code   = code_q;

endmodule

// File: tb/tb_ans_bcd_convert.sv
// Bench for ans_bcd_convert: directed cases plus random traffic against a
// latency/arithmetic model; every cycle all outputs are compared.
// Honours ANS_BCD_BLANK_EN when defined for the build.
module tb_ans_bcd_convert;

  logic        sw_clk = 1'b0;
  logic        rst    = 1'b1;
  logic        start  = 1'b0;
  logic [31:0] ans    = 32'd0;
  logic        busy, done, neg;
  logic [23:0] digits;
  logic [1:0]  code;

  int checks   = 0;
  int failures = 0;

  ans_bcd_convert dut (
    .sw_clk (sw_clk),
    .rst    (rst),
    .start  (start),
    .ans    (ans),
    .busy   (busy),
    .done   (done),
    .digits (digits),
    .neg    (neg),
    .code   (code)
  );

  always #5 sw_clk = ~sw_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Arithmetic reference: decimal digits by repeated division.
  function automatic void model(input logic [31:0] a, output logic [23:0] d,
                                output logic n, output logic [1:0] c);
    int v, m, top;
    d = 24'd0;
    n = 1'b0;
    v = $signed(a);
    if (a == 32'h00CC_0000) c = 2'd1;
    else if (a == 32'h00EE_0000 || v < -99999 || v > 999999) c = 2'd2;
    else begin
      c = 2'd0;
      n = (v < 0);
      m = n ? -v : v;
      for (int i = 0; i < 6; i++) begin
        d[i*4 +: 4] = 4'(m % 10);
        m = m / 10;
      end
    end
`ifdef ANS_BCD_BLANK_EN
    if (c != 2'd0) d = 24'hFFFFFF;
    else begin
      top = 0;
      for (int i = 0; i < 6; i++) if (d[i*4 +: 4] != 4'd0) top = i;
      for (int i = top + 1; i < 6; i++) d[i*4 +: 4] = 4'hF;
      if (n && top < 5) d[(top+1)*4 +: 4] = 4'hA;
    end
`endif
  endfunction

  // Cycle model: cycles remaining until the result appears.
  int          m_left = 0;
  logic        e_done = 1'b0, e_neg = 1'b0, p_neg = 1'b0;
  logic [23:0] e_dig  = 24'd0, p_dig = 24'd0;
  logic [1:0]  e_code = 2'd0, p_code = 2'd0;

  always @(posedge sw_clk or negedge rst) begin
    if (!rst) begin
      m_left = 0; e_done = 1'b0; e_dig = 24'd0; e_neg = 1'b0; e_code = 2'd0;
    end else begin
      e_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          e_dig = p_dig; e_neg = p_neg; e_code = p_code; e_done = 1'b1;
        end
      end else if (start) begin
        model(ans, p_dig, p_neg, p_code);
        m_left = (p_code != 2'd0) ? 1 : 21;
      end
    end
  end

  always @(negedge sw_clk) begin
    chk("busy",   {31'd0, busy}, {31'd0, (m_left > 0)});
    chk("done",   {31'd0, done}, {31'd0, e_done});
    chk("digits", {8'd0, digits}, {8'd0, e_dig});
    chk("neg",    {31'd0, neg},  {31'd0, e_neg});
    chk("code",   {30'd0, code}, {30'd0, e_code});
  end

  task automatic do_start(input logic [31:0] a);
    @(posedge sw_clk); #2;
    ans = a; start = 1'b1;
    @(posedge sw_clk); #2;
    start = 1'b0;
  endtask

  // Negedges from the accepting edge until done is seen (bounded).
  task automatic wait_done(output int n);
    logic got;
    n = 0; got = 1'b0;
    while (n < 60 && !got) begin
      @(negedge sw_clk);
      n++;
      got = done;
    end
  endtask

  function automatic logic [31:0] rand_ans();
    logic [31:0] r;
    case ($urandom_range(0, 7))
      0: r = 32'h00CC_0000;
      1: r = 32'h00EE_0000;
      2: r = $urandom_range(0, 999999);
      3: r = 32'(-int'($urandom_range(0, 99999)));
      4: case ($urandom_range(0, 4))
           0: r = 32'd999999;
           1: r = 32'd1000000;
           2: r = 32'(-99999);
           3: r = 32'(-100000);
           default: r = 32'd0;
         endcase
      5: r = $urandom;
      6: r = $urandom_range(0, 99);
      default: r = 32'(-int'($urandom_range(1, 99)));
    endcase
    return r;
  endfunction

  logic [23:0] md;
  logic        mn;
  logic [1:0]  mc;
  int          n;
  int          extra;

  initial begin
    // Pin the model to hand-computed values.
    model(32'd123456, md, mn, mc);
    chk("pin_123456", {8'd0, md}, 32'h00123456);
    model(32'hFFFE7961, md, mn, mc);
`ifdef ANS_BCD_BLANK_EN
    chk("pin_m99999", {8'd0, md}, 32'h00A99999);
`else
    chk("pin_m99999", {8'd0, md}, 32'h00099999);
`endif
    chk("pin_m99999_neg", {31'd0, mn}, 32'd1);
    model(32'h00CC_0000, md, mn, mc);
    chk("pin_null", {30'd0, mc}, 32'd1);
    model(32'd1000000, md, mn, mc);
    chk("pin_ovf", {30'd0, mc}, 32'd2);

    #1 rst = 1'b0;
    @(negedge sw_clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_digits", {8'd0, digits}, 32'd0);
    chk("rst_code", {30'd0, code}, 32'd0);
    @(posedge sw_clk); #2 rst = 1'b1;

    do_start(32'd123456); wait_done(n);
    chk("lat_num", n, 32'd22);
`ifdef ANS_BCD_BLANK_EN
    chk("d_123456", {8'd0, digits}, 32'h00123456);
`else
    chk("d_123456", {8'd0, digits}, 32'h00123456);
`endif
    chk("n_123456", {31'd0, neg}, 32'd0);

    do_start(32'hFFFE7961); wait_done(n);
`ifdef ANS_BCD_BLANK_EN
    chk("d_m99999", {8'd0, digits}, 32'h00A99999);
`else
    chk("d_m99999", {8'd0, digits}, 32'h00099999);
`endif
    chk("n_m99999", {31'd0, neg}, 32'd1);

    do_start(32'h00CC_0000); wait_done(n);
    chk("lat_null", n, 32'd2);
    chk("c_null", {30'd0, code}, 32'd1);
    do_start(32'h00EE_0000); wait_done(n);
    chk("c_ovfcode", {30'd0, code}, 32'd2);
    do_start(32'd1000000); wait_done(n);
    chk("c_1e6", {30'd0, code}, 32'd2);
    do_start(32'(-100000)); wait_done(n);
    chk("c_m1e5", {30'd0, code}, 32'd2);
    chk("n_m1e5", {31'd0, neg}, 32'd0);

    do_start(32'd0); wait_done(n);
`ifdef ANS_BCD_BLANK_EN
    chk("d_zero", {8'd0, digits}, 32'h00FFFFF0);
`else
    chk("d_zero", {8'd0, digits}, 32'h00000000);
`endif
    do_start(32'd999999); wait_done(n);
    chk("d_999999", {8'd0, digits}, 32'h00999999);

    // Start during SHIFT must be dropped.
    do_start(32'd555555);
    repeat (4) @(posedge sw_clk);
    #2 ans = 32'd7; start = 1'b1;
    @(posedge sw_clk); #2 start = 1'b0; ans = 32'd0;
    wait_done(n);
    chk("d_555555", {8'd0, digits}, 32'h00555555);
    extra = 0;
    repeat (30) begin
      @(negedge sw_clk);
      if (done) extra++;
    end
    chk("no_second_done", extra, 32'd0);

    // Reset mid-conversion.
    do_start(32'd555555);
    repeat (10) @(posedge sw_clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_digits", {8'd0, digits}, 32'd0);
    chk("mid_rst_code", {30'd0, code}, 32'd0);
    @(posedge sw_clk); #2 rst = 1'b1;
    do_start(32'd42); wait_done(n);
    chk("lat_42", n, 32'd22);
`ifdef ANS_BCD_BLANK_EN
    chk("d_42", {8'd0, digits}, 32'h00FFFF42);
`else
    chk("d_42", {8'd0, digits}, 32'h00000042);
`endif

    // Random traffic, including starts while busy.
    repeat (3000) begin
      @(posedge sw_clk); #2;
      start = ($urandom_range(0, 3) == 0);
      ans   = rand_ans();
    end
    #0 start = 1'b0;
    repeat (30) @(posedge sw_clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
